tick_gen_multi: RTL and testbench

- Multi-channel, parametrised successor to the single-counter clock divider. Generates per-channel registered tick pulses at a programmable period of vmax+1 enabled cycles.
- Adds per-channel start/stop control, one-shot or continuous mode, pause via enable, and a half-period initial phase for mid-bit UART RX sampling.
- Sits between the RS232 TX/RX FSMs and the system clock; one channel per baud/timeout consumer.

---
 rtl/tick_gen_pkg.sv | 29 ++
 rtl/tick_chan.sv | 85 ++++++++
 rtl/tick_gen_multi.sv | 38 +++
 tb/tb_tick_gen_multi.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared encodings and the half-phase load helper for the tick generator.
package tick_gen_pkg;

  // Widest counter the load helper supports.
  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Start value for the counter: 0, or (vmax+1)>>1 for a mid-period first tick.
  // The +1 is done one bit wider so vmax = all-ones does not wrap.
  function automatic logic [MAX_W-1:0] half_load(input logic [MAX_W-1:0] vmax,
                                                 input logic             half);
    logic [MAX_W:0] sum;
    sum = {1'b0, vmax} + (MAX_W+1)'(1);
    if (half) begin
      return MAX_W'(sum >> 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: IDLE/RUN state machine, period counter and tick register.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_half,
  input  logic             i_mode,
  input  logic [Width-1:0] i_vmax,
  output logic             o_tick,
  output logic             o_busy
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [Width-1:0]   r_cnt;
  logic [Width-1:0]   w_cnt_nxt;
  logic               r_tick;
  logic               w_tick_nxt;
  logic [Width-1:0]   w_load;
  logic               w_term;

  assign w_load = Width'(half_load(MAX_W'(i_vmax), i_half));
  // >= so a divisor lowered below the running count still terminates.
  assign w_term = (r_cnt >= i_vmax);

  // Next-state, next-count and tick decision; start overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    if (i_start) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = w_load;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
        end
        ST_RUN: begin
          if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (i_en) begin
            if (w_term) begin
              w_cnt_nxt  = '0;
              w_tick_nxt = 1'b1;
              if (mode_e'(i_mode) == MODE_ONESHOT) begin
                w_state_nxt = ST_IDLE;
              end
            end else begin
              w_cnt_nxt = r_cnt + Width'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and tick registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign o_tick = r_tick;
  assign o_busy = (r_state == ST_RUN);

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: one independent tick_chan per consumer.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int unsigned Width    = 16,
  parameter int unsigned Channels = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [Channels-1:0]       en_i,
  input  logic [Channels-1:0]       start_i,
  input  logic [Channels-1:0]       stop_i,
  input  logic [Channels-1:0]       half_i,
  input  logic [Channels-1:0]       mode_i,
  input  logic [Channels*Width-1:0] vmax_i,
  output logic [Channels-1:0]       tick_o,
  output logic [Channels-1:0]       busy_o
);

  // Slice the packed divisor bus and build one channel per slice.
  for (genvar k = 0; k < int'(Channels); k++) begin : g_chan
    tick_chan #(
      .Width(Width)
    ) u_chan (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_en    (en_i[k]),
      .i_start (start_i[k]),
      .i_stop  (stop_i[k]),
      .i_half  (half_i[k]),
      .i_mode  (mode_i[k]),
      .i_vmax  (vmax_i[k*Width +: Width]),
      .o_tick  (tick_o[k]),
      .o_busy  (busy_o[k])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi against a rule-level reference model.
module tb_tick_gen_multi;

  localparam int unsigned W  = 16;
  localparam int unsigned CH = 2;

  logic              clk_i;
  logic              rst_ni;
  logic [CH-1:0]     en_i;
  logic [CH-1:0]     start_i;
  logic [CH-1:0]     stop_i;
  logic [CH-1:0]     half_i;
  logic [CH-1:0]     mode_i;
  logic [CH*W-1:0]   vmax_i;
  logic [CH-1:0]     tick_o;
  logic [CH-1:0]     busy_o;

  tick_gen_multi #(.Width(W), .Channels(CH)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (en_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .half_i  (half_i),
    .mode_i  (mode_i),
    .vmax_i  (vmax_i),
    .tick_o  (tick_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [CH-1:0] tick;
    logic [CH-1:0] busy;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_no = 0;

  // Reference model: running flag and elapsed count per channel.
  bit   m_run[CH];
  int   m_cnt[CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
  endtask

  function automatic int vmax_of(input int k);
    logic [W-1:0] v;
    v = vmax_i[k*W +: W];
    return int'(v);
  endfunction

  // Apply the channel rules to the inputs present now; queue the outputs due after the next edge.
  task automatic model_push();
    exp_t e;
    e.tick = '0;
    e.busy = '0;
    e.cyc  = cyc_no;
    for (int k = 0; k < int'(CH); k++) begin
      int v;
      v = vmax_of(k);
      if (!rst_ni) begin
        m_run[k] = 1'b0;
        m_cnt[k] = 0;
      end else if (start_i[k]) begin
        m_run[k] = 1'b1;
        m_cnt[k] = half_i[k] ? (v + 1) / 2 : 0;
      end else if (m_run[k] && stop_i[k]) begin
        m_run[k] = 1'b0;
        m_cnt[k] = 0;
      end else if (m_run[k] && en_i[k]) begin
        if (m_cnt[k] >= v) begin
          e.tick[k] = 1'b1;
          m_cnt[k]  = 0;
          if (mode_i[k]) m_run[k] = 1'b0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      e.busy[k] = m_run[k];
    end
    q.push_back(e);
  endtask

  task automatic cyc();
    model_push();
    @(negedge clk_i);
    cyc_no++;
    start_i = '0;
    stop_i  = '0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_vmax(input int k, input int v);
    vmax_i[k*W +: W] = W'(v);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("tick_o", 32'(tick_o), 32'(e.tick), e.cyc);
        chk("busy_o", 32'(busy_o), 32'(e.busy), e.cyc);
      end
    end
  end

  initial begin
    for (int k = 0; k < int'(CH); k++) begin
      m_run[k] = 1'b0;
      m_cnt[k] = 0;
    end
    rst_ni  = 1'b0;
    en_i    = '0;
    start_i = '0;
    stop_i  = '0;
    half_i  = '0;
    mode_i  = '0;
    vmax_i  = '0;
    #2;
    chk("reset_tick", 32'(tick_o), 32'(0), 0);
    chk("reset_busy", 32'(busy_o), 32'(0), 0);
    @(negedge clk_i);
    run(2);
    rst_ni = 1'b1;
    run(2);

    // Continuous, vmax=9, full period.
    set_vmax(0, 9);
    en_i       = 2'b11;
    start_i[0] = 1'b1;
    run(41);
    stop_i[0] = 1'b1;
    run(2);

    // Half-phase on ch0 alongside ch1 at vmax=3.
    set_vmax(0, 9);
    set_vmax(1, 3);
    half_i  = 2'b01;
    start_i = 2'b11;
    run(32);
    stop_i = 2'b11;
    run(2);
    half_i = '0;

    // One-shot vmax=4, twice.
    set_vmax(0, 4);
    mode_i[0]  = 1'b1;
    start_i[0] = 1'b1;
    run(26);
    start_i[0] = 1'b1;
    run(8);
    mode_i[0] = 1'b0;

    // Pause mid-period, vmax=7.
    set_vmax(0, 7);
    start_i[0] = 1'b1;
    cyc();
    run(3);
    en_i[0] = 1'b0;
    run(6);
    en_i[0] = 1'b1;
    run(10);
    // Start and stop together: restart wins.
    start_i[0] = 1'b1;
    stop_i[0]  = 1'b1;
    run(5);
    // Stop on the terminal cycle.
    start_i[0] = 1'b1;
    cyc();
    run(7);
    stop_i[0] = 1'b1;
    run(6);

    // vmax=0 continuous: tick every enabled cycle.
    set_vmax(0, 0);
    start_i[0] = 1'b1;
    run(8);
    en_i[0] = 1'b0;
    run(2);
    en_i[0] = 1'b1;
    run(3);

    // Lower vmax below the running count.
    set_vmax(0, 100);
    start_i[0] = 1'b1;
    run(51);
    set_vmax(0, 3);
    run(12);

    // Asynchronous reset between edges mid-count.
    set_vmax(0, 20);
    set_vmax(1, 20);
    start_i = 2'b11;
    run(7);
    model_push();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_tick", 32'(tick_o), 32'(0), cyc_no);
    chk("async_rst_busy", 32'(busy_o), 32'(0), cyc_no);
    @(negedge clk_i);
    cyc_no++;
    model_push();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(negedge clk_i);
    cyc_no++;
    run(25);
    start_i = 2'b11;
    run(25);

    // Randomised traffic.
    for (int k = 0; k < int'(CH); k++) set_vmax(k, int'($urandom_range(0, 12)));
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < int'(CH); k++) begin
        en_i[k]    = ($urandom % 8) != 0;
        start_i[k] = ($urandom % 30) == 0;
        stop_i[k]  = ($urandom % 50) == 0;
        half_i[k]  = $urandom % 2;
        if (($urandom % 100) == 0) mode_i[k] = ~mode_i[k];
        if (($urandom % 150) == 0) set_vmax(k, int'($urandom_range(0, 15)));
      end
      cyc();
    end

    en_i = '0;
    @(posedge clk_i);
    #2;
    chk("queue_drained", 32'(q.size()), 32'(0), cyc_no);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
